seq_alu: RTL and testbench

Multi-cycle execute unit that consumes the 4-bit ALUControl code produced by the ALU decoder and returns the result over a valid/ready handshake. Logic, arithmetic and compare ops complete in one cycle. Shifts run iteratively, SHIFT_STEP bit positions per cycle, to keep the barrel shifter off the critical path. Sits between the decode stage and the writeback mux in the multi-cycle core variant.

---
 rtl/seq_alu_if.sv | 46 ++++
 rtl/seq_alu.sv | 241 ++++++++++++++++++++++++
 tb/tb_seq_alu.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/seq_alu_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_alu_if
//  Description : Request/response bundle between the decode stage and the
//                sequential execute unit.
//                Request  : in_valid / in_ready, alu_control, src_a, src_b
//                Response : out_valid / out_ready, result, zero, illegal
//                           (+ carry, overflow when SEQ_ALU_FLAGS_EN is set)
//                Modports : master = issuing side, slave = execute unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_control;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;
`ifdef SEQ_ALU_FLAGS_EN
    logic             carry;
    logic             overflow;
`endif

    modport master (
        output in_valid, alu_control, src_a, src_b, out_ready,
        input  in_ready, out_valid, result, zero, illegal
`ifdef SEQ_ALU_FLAGS_EN
        , input carry, overflow
`endif
    );

    modport slave (
        input  in_valid, alu_control, src_a, src_b, out_ready,
        output in_ready, out_valid, result, zero, illegal
`ifdef SEQ_ALU_FLAGS_EN
        , output carry, overflow
`endif
    );
endinterface
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
//  Module      : seq_alu
//  Description : Multi-cycle execute unit. Logic, add/sub and compare ops
//                finish one cycle after accept; shifts iterate SHIFT_STEP
//                bit positions per cycle. Results are returned over a
//                valid/ready handshake and held until consumed.
//  Ports       : clk      - clock, rising edge
//                reset_n  - synchronous active-low reset
//                bus      - seq_alu_if.slave (request + response handshake)
//  Options     : SEQ_ALU_FLAGS_EN - adds registered carry/overflow outputs
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_alu #(
    parameter int WIDTH      = 32,
    parameter int SHIFT_STEP = 1
) (
    input  wire logic  clk,
    input  wire logic  reset_n,
    seq_alu_if.slave   bus
);

    // shamt field width, and counter width wide enough to hold SHIFT_STEP
    // even when SHIFT_STEP == WIDTH (WIDTH=8, STEP=8).
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;

    localparam logic [CW-1:0] c_STEP = CW'(SHIFT_STEP);

    localparam logic [3:0] c_OP_AND  = 4'b0000;
    localparam logic [3:0] c_OP_OR   = 4'b0001;
    localparam logic [3:0] c_OP_ADD  = 4'b0010;
    localparam logic [3:0] c_OP_SUB  = 4'b0110;
    localparam logic [3:0] c_OP_XOR  = 4'b0100;
    localparam logic [3:0] c_OP_SLT  = 4'b0111;
    localparam logic [3:0] c_OP_SLTU = 4'b1000;
    localparam logic [3:0] c_OP_SLL  = 4'b1010;
    localparam logic [3:0] c_OP_SRL  = 4'b1011;
    localparam logic [3:0] c_OP_SRA  = 4'b1100;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             illegal_q, illegal_d;
    logic [3:0]       code_q, code_d;
    logic [CW-1:0]    rem_q, rem_d;
`ifdef SEQ_ALU_FLAGS_EN
    logic             carry_q, carry_d;
    logic             overflow_q, overflow_d;
`endif

    logic             w_accept;
    logic [CW-1:0]    w_shamt;
    logic [CW-1:0]    w_k;
    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_add;
    logic [WIDTH-1:0] w_sub;
    logic             w_slt;
    logic             w_sltu;

    // ------------------------------------------------------------------
    // Single-cycle datapath, evaluated on the request operands so the
    // result can be latched on the accept edge.
    // ------------------------------------------------------------------
`ifdef SEQ_ALU_FLAGS_EN
    logic [WIDTH:0] w_add_ext;
    logic [WIDTH:0] w_sub_ext;
    logic           w_add_ovf;
    logic           w_sub_ovf;

    // Subtraction as a + ~b + 1 so bit WIDTH is the no-borrow flag.
    assign w_add_ext = {1'b0, bus.src_a} + {1'b0, bus.src_b};
    assign w_sub_ext = {1'b0, bus.src_a} + {1'b0, ~bus.src_b} + (WIDTH+1)'(1);
    assign w_add     = w_add_ext[WIDTH-1:0];
    assign w_sub     = w_sub_ext[WIDTH-1:0];

    // Signed overflow: operands of the relevant signs disagree with result.
    assign w_add_ovf = (bus.src_a[WIDTH-1] == bus.src_b[WIDTH-1]) &&
                       (w_add[WIDTH-1]     != bus.src_a[WIDTH-1]);
    assign w_sub_ovf = (bus.src_a[WIDTH-1] != bus.src_b[WIDTH-1]) &&
                       (w_sub[WIDTH-1]     != bus.src_a[WIDTH-1]);
`else
    assign w_add = bus.src_a + bus.src_b;
    assign w_sub = bus.src_a - bus.src_b;
`endif

    assign w_slt  = $signed(bus.src_a) < $signed(bus.src_b);
    assign w_sltu = bus.src_a < bus.src_b;

    assign w_shamt  = {1'b0, bus.src_b[SHW-1:0]};

    // Acceptance is blocked while reset is asserted so nothing is taken
    // on the reset edge and in_ready reads low throughout reset.
    assign bus.in_ready = reset_n && (state_q == S_IDLE);
    assign w_accept     = bus.in_valid && bus.in_ready;

    // ------------------------------------------------------------------
    // Iterative shifter: at most SHIFT_STEP positions per cycle, with the
    // final step trimmed to whatever distance remains.
    // ------------------------------------------------------------------
    assign w_k = (rem_q < c_STEP) ? rem_q : c_STEP;

    always_comb begin
        w_shifted = result_q;
        case (code_q)
            c_OP_SLL: w_shifted = result_q << w_k;
            c_OP_SRL: w_shifted = result_q >> w_k;
            c_OP_SRA: w_shifted = $unsigned($signed(result_q) >>> w_k);
            default:  w_shifted = result_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state / datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        code_d    = code_q;
        rem_d     = rem_q;
`ifdef SEQ_ALU_FLAGS_EN
        carry_d    = carry_q;
        overflow_d = overflow_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    code_d    = bus.alu_control;
                    illegal_d = 1'b0;
                    rem_d     = '0;
                    state_d   = S_DONE;
`ifdef SEQ_ALU_FLAGS_EN
                    carry_d    = 1'b0;
                    overflow_d = 1'b0;
`endif
                    case (bus.alu_control)
                        c_OP_AND:  result_d = bus.src_a & bus.src_b;
                        c_OP_OR:   result_d = bus.src_a | bus.src_b;
                        c_OP_XOR:  result_d = bus.src_a ^ bus.src_b;
                        c_OP_ADD: begin
                            result_d = w_add;
`ifdef SEQ_ALU_FLAGS_EN
                            carry_d    = w_add_ext[WIDTH];
                            overflow_d = w_add_ovf;
`endif
                        end
                        c_OP_SUB: begin
                            result_d = w_sub;
`ifdef SEQ_ALU_FLAGS_EN
                            carry_d    = w_sub_ext[WIDTH];
                            overflow_d = w_sub_ovf;
`endif
                        end
                        c_OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, w_slt};
                        c_OP_SLTU: result_d = {{(WIDTH-1){1'b0}}, w_sltu};
                        c_OP_SLL, c_OP_SRL, c_OP_SRA: begin
                            // Zero distance finishes immediately with src_a.
                            result_d = bus.src_a;
                            if (w_shamt != '0) begin
                                rem_d   = w_shamt;
                                state_d = S_SHIFT;
                            end
                        end
                        default: begin
                            result_d  = '0;
                            illegal_d = 1'b1;
                        end
                    endcase
                    zero_d = (result_d == '0);
                end
            end

            S_SHIFT: begin
                result_d = w_shifted;
                zero_d   = (w_shifted == '0);
                rem_d    = rem_q - w_k;
                if (rem_q == w_k) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                // Outputs are frozen here until the consumer takes them.
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
            code_q    <= '0;
            rem_q     <= '0;
`ifdef SEQ_ALU_FLAGS_EN
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            code_q    <= code_d;
            rem_q     <= rem_d;
`ifdef SEQ_ALU_FLAGS_EN
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
`endif
        end
    end

    assign bus.out_valid = (state_q == S_DONE);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.illegal   = illegal_q;
`ifdef SEQ_ALU_FLAGS_EN
    assign bus.carry     = carry_q;
    assign bus.overflow  = overflow_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_alu
//  Description : Directed self-checking bench for seq_alu. Two instances
//                (SHIFT_STEP=1 and SHIFT_STEP=4) receive identical stimulus;
//                each is checked against hand-computed results and its own
//                expected latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_alu;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(32)) b1 ();
    seq_alu_if #(.WIDTH(32)) b4 ();

    seq_alu #(.WIDTH(32), .SHIFT_STEP(1)) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b1.slave)
    );

    seq_alu #(.WIDTH(32), .SHIFT_STEP(4)) dut4 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b4.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] code,
                         input logic [31:0] a, input logic [31:0] b, input logic ordy);
        b1.in_valid = v;  b1.alu_control = code;  b1.src_a = a;  b1.src_b = b;  b1.out_ready = ordy;
        b4.in_valid = v;  b4.alu_control = code;  b4.src_a = a;  b4.src_b = b;  b4.out_ready = ordy;
    endtask

    // Wait for both units to be ready, present the request, and return
    // just after the accepting edge with the inputs scrambled.
    task automatic issue(input logic [3:0] code, input logic [31:0] a,
                         input logic [31:0] b, input logic ordy);
        int t;
        t = 0;
        while (!(b1.in_ready && b4.in_ready) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("issue_ready", 64'(b1.in_ready && b4.in_ready), 64'd1);
        drive(1'b1, code, a, b, ordy);
        @(posedge clk);
        #1;
        drive(1'b0, 4'($urandom), $urandom, $urandom, ordy);
    endtask

    task automatic op(input string tag, input logic [3:0] code,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp_r, input logic exp_z, input logic exp_ill,
                      input logic exp_c, input logic exp_v,
                      input int lat1, input int lat4);
        logic got1, got4;
        got1 = 1'b0;
        got4 = 1'b0;
        issue(code, a, b, 1'b1);
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (!got1 && b1.out_valid) begin
                got1 = 1'b1;
                check({tag, "_lat_s1"}, 64'(c), 64'(lat1));
                check({tag, "_res_s1"}, 64'(b1.result), 64'(exp_r));
                check({tag, "_zero_s1"}, 64'(b1.zero), 64'(exp_z));
                check({tag, "_ill_s1"}, 64'(b1.illegal), 64'(exp_ill));
`ifdef SEQ_ALU_FLAGS_EN
                check({tag, "_carry_s1"}, 64'(b1.carry), 64'(exp_c));
                check({tag, "_ovf_s1"}, 64'(b1.overflow), 64'(exp_v));
`endif
            end
            if (!got4 && b4.out_valid) begin
                got4 = 1'b1;
                check({tag, "_lat_s4"}, 64'(c), 64'(lat4));
                check({tag, "_res_s4"}, 64'(b4.result), 64'(exp_r));
                check({tag, "_zero_s4"}, 64'(b4.zero), 64'(exp_z));
                check({tag, "_ill_s4"}, 64'(b4.illegal), 64'(exp_ill));
`ifdef SEQ_ALU_FLAGS_EN
                check({tag, "_carry_s4"}, 64'(b4.carry), 64'(exp_c));
                check({tag, "_ovf_s4"}, 64'(b4.overflow), 64'(exp_v));
`endif
            end
            if (got1 && got4) break;
        end
        check({tag, "_done_s1"}, 64'(got1), 64'd1);
        check({tag, "_done_s4"}, 64'(got4), 64'd1);
    endtask

    initial begin
        reset_n = 1'b0;
        drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);

        // Reset held three cycles, in_ready low throughout.
        repeat (3) begin
            @(negedge clk);
            check("rst_in_ready", 64'(b1.in_ready | b4.in_ready), 64'd0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready_s1", 64'(b1.in_ready), 64'd1);
        check("rel_in_ready_s4", 64'(b4.in_ready), 64'd1);
        check("rel_out_valid", 64'(b1.out_valid | b4.out_valid), 64'd0);
        check("rel_result", 64'(b1.result | b4.result), 64'd0);
        check("rel_illegal", 64'(b1.illegal | b4.illegal), 64'd0);
        check("rel_zero", 64'(b1.zero | b4.zero), 64'd0);

        //  tag       code     a             b             result        z     ill   c     v     l1  l4
        op("add_ovf",  4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1,  1);
        op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1,  1);
        op("sub_eq",   4'b0110, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1,  1);
        op("sub_brw",  4'b0110, 32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1,  1);
        op("slt",      4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0, 1,  1);
        op("sltu",     4'b1000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1,  1);
        op("and",      4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0, 1'b0, 1'b0, 1'b0, 1,  1);
        op("or",       4'b0001, 32'h1200_0000, 32'h0034_0056, 32'h1234_0056, 1'b0, 1'b0, 1'b0, 1'b0, 1,  1);
        op("xor",      4'b0100, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0, 1'b0, 1'b0, 1'b0, 1,  1);
        op("sra31",    4'b1100, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 32, 9);
        op("sra_pos",  4'b1100, 32'h7000_0000, 32'h0000_0005, 32'h0380_0000, 1'b0, 1'b0, 1'b0, 1'b0, 6,  3);
        op("sra_sh0",  4'b1100, 32'hDEAD_BEEF, 32'h0000_0020, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0, 1,  1);
        op("srl4",     4'b1011, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0, 1'b0, 1'b0, 1'b0, 5,  2);
        op("sll7",     4'b1010, 32'h0000_0001, 32'h0000_0007, 32'h0000_0080, 1'b0, 1'b0, 1'b0, 1'b0, 8,  3);
        op("ill_0011", 4'b0011, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0, 1,  1);

        // Illegal code with the consumer stalled: outputs must hold.
        issue(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("hold_valid", 64'(b1.out_valid), 64'd1);
            check("hold_result", 64'(b1.result), 64'd0);
            check("hold_illegal", 64'(b1.illegal), 64'd1);
            check("hold_in_ready", 64'(b1.in_ready | b4.in_ready), 64'd0);
        end
        b1.out_ready = 1'b1;
        b4.out_ready = 1'b1;
        @(negedge clk);
        check("hold_rel_in_ready", 64'(b1.in_ready), 64'd1);
        check("hold_rel_valid", 64'(b1.out_valid), 64'd0);

        // Reset in the middle of a long shift aborts it.
        issue(4'b1010, 32'h0000_0001, 32'h0000_0014, 1'b1);
        repeat (5) @(negedge clk);
        check("mid_busy", 64'(b1.out_valid | b4.out_valid), 64'd0);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 64'(b1.out_valid | b4.out_valid), 64'd0);
        check("mid_rst_result_s1", 64'(b1.result), 64'd0);
        check("mid_rst_result_s4", 64'(b4.result), 64'd0);
        check("mid_rst_in_ready", 64'(b1.in_ready | b4.in_ready), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("mid_rel_in_ready", 64'(b1.in_ready && b4.in_ready), 64'd1);
        op("post_rst_add", 4'b0010, 32'h0000_1000, 32'h0000_0234, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
